// File: rtl/aespim_keyexp_engine_pkg.sv
// ---------------------------------------------------------------------------
// aespim_pkg
// Shared types and helpers for the aespim key-schedule engine.
//   keyexp_state_e : engine sequencing states (IDLE / EXPAND / DONE)
//   RCON_INIT      : first round constant of the schedule
//   AES_RK_WORDS   : number of 32-bit round-key words for a given Nk
//   aes_xtime      : multiply-by-x in GF(2^8) modulo x^8+x^4+x^3+x+1
//   gf_mul/gf_inv  : GF(2^8) multiply and multiplicative inverse
//   aes_affine     : forward S-box affine transform
//   aes_inv_affine : inverse S-box affine transform
// ---------------------------------------------------------------------------
package aespim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } keyexp_state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Nr = Nk + 6 rounds, each needing four words, plus the initial key.
    function automatic int AES_RK_WORDS(input int nk);
        return 4 * (nk + 7);
    endfunction

    function automatic logic [7:0] aes_xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Shift-and-add multiply; unrolls into a fixed XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                acc = acc ^ aa;
            end
            aa = aes_xtime(aa);
        end
        return acc;
    endfunction

    // x^254 is the inverse of x in GF(2^8) and naturally maps 0 to 0.
    // Built as x^2 * x^4 * ... * x^128 by repeated squaring.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int k = 0; k < 6; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] aes_affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aes_inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

endpackage

// File: rtl/aespim_keyexp_engine_if.sv
// ---------------------------------------------------------------------------
// aespim_keyexp_engine_if
// Bus bundle between the datapath (master) and the key-schedule engine
// (slave).
//   key_we_i/key_idx_i/key_data_i : word-serial initial key load
//   start_i                       : begin expansion
//   busy_o/done_o                 : expansion status / completion pulse
//   rk_addr_i/rk_data_o           : round-key read port (1-cycle latency)
// ---------------------------------------------------------------------------
interface aespim_keyexp_engine_if
    import aespim_pkg::*;
#(
    parameter int KEY_WORDS = 4
) ();

    localparam int RK_WORDS = AES_RK_WORDS(KEY_WORDS);
    localparam int ADDR_W   = $clog2(RK_WORDS);
    localparam int IDX_W    = $clog2(KEY_WORDS);

    logic              key_we_i;
    logic [IDX_W-1:0]  key_idx_i;
    logic [31:0]       key_data_i;
    logic              start_i;
    logic              busy_o;
    logic              done_o;
    logic [ADDR_W-1:0] rk_addr_i;
    logic [31:0]       rk_data_o;

    modport master (
        output key_we_i, key_idx_i, key_data_i, start_i, rk_addr_i,
        input  busy_o, done_o, rk_data_o
    );

    modport slave (
        input  key_we_i, key_idx_i, key_data_i, start_i, rk_addr_i,
        output busy_o, done_o, rk_data_o
    );

endinterface

// File: rtl/aespim_keyexp_engine_subword.sv
// ---------------------------------------------------------------------------
// bSbox
// Single AES byte S-box, forward or inverse.
//   A       : input byte
//   encrypt : 1 = forward S-box, 0 = inverse S-box
//   Q       : substituted byte
//
// aespim_subword
// AES SubWord: four forward S-boxes applied bytewise to a 32-bit word.
//   word_i : input word
//   word_o : substituted word
// ---------------------------------------------------------------------------
module bSbox
    import aespim_pkg::*;
(
    input  logic [7:0] A,
    input  logic       encrypt,
    output logic [7:0] Q
);

    logic [7:0] invIn;
    logic [7:0] invOut;

    // The forward box is inverse-then-affine; the inverse box undoes the
    // affine step first and then inverts, sharing one GF inverter.
    always_comb begin
        invIn  = encrypt ? A : aes_inv_affine(A);
        invOut = gf_inv(invIn);
        Q      = encrypt ? aes_affine(invOut) : invOut;
    end

endmodule

module aespim_subword (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    // One S-box per byte lane, always in forward mode for key expansion.
    for (genvar b = 0; b < 4; b++) begin : g_sbox
        bSbox u_sbox (
            .A       (word_i[8*b +: 8]),
            .encrypt (1'b1),
            .Q       (word_o[8*b +: 8])
        );
    end

endmodule

// File: rtl/aespim_keyexp_engine.sv
// ---------------------------------------------------------------------------
// aespim_keyexp_engine
// Self-sequenced AES-128/AES-256 key-schedule generator. The initial key is
// loaded word-serially, a start command expands the full schedule at one
// word per cycle, and the round keys are read back from an internal buffer.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus     : slave side of aespim_keyexp_engine_if (key load, start,
//             busy/done status, round-key read port)
// Parameters:
//   KEY_WORDS : Nk, 4 (AES-128) or 8 (AES-256)
// ---------------------------------------------------------------------------
module aespim_keyexp_engine
    import aespim_pkg::*;
#(
    parameter int KEY_WORDS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    aespim_keyexp_engine_if.slave bus
);

    localparam int RK_WORDS = AES_RK_WORDS(KEY_WORDS);
    localparam int ADDR_W   = $clog2(RK_WORDS);
    localparam int IDX_W    = $clog2(KEY_WORDS);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_EXPAND = EXPAND;
    localparam logic [1:0] ST_DONE   = DONE;

    localparam logic [ADDR_W-1:0] CNT_INIT = ADDR_W'(KEY_WORDS);
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(RK_WORDS - 1);
    localparam logic [IDX_W-1:0]  PH_LAST  = IDX_W'(KEY_WORDS - 1);
    localparam logic [IDX_W-1:0]  PH_HALF  = IDX_W'(KEY_WORDS / 2);

    if (KEY_WORDS != 4 && KEY_WORDS != 8) begin : g_bad_key_words
        $error("aespim_keyexp_engine: KEY_WORDS must be 4 or 8");
    end

    logic [1:0]        state_q, state_d;
    logic [31:0]       win_q [KEY_WORDS];
    logic [31:0]       win_d [KEY_WORDS];
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  phase_q, phase_d;
    logic [7:0]        rcon_q, rcon_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       buf_q [RK_WORDS];

    logic              bufWe;
    logic [ADDR_W-1:0] bufWaddr;
    logic [31:0]       bufWdata;

    logic [31:0]       prevWord;
    logic [31:0]       subIn;
    logic [31:0]       subOut;
    logic [31:0]       tWord;
    logic [31:0]       newWord;

    // The newest window slot is w[i-1]; RotWord is applied only at the start
    // of each Nk-word group, so one SubWord unit serves both cases.
    assign prevWord = win_q[KEY_WORDS-1];
    assign subIn    = (phase_q == '0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;

    aespim_subword u_subword (
        .word_i (subIn),
        .word_o (subOut)
    );

    // Temp word selection: group start gets SubWord(RotWord) plus rcon,
    // AES-256 additionally substitutes the middle word of each group, and
    // every other word passes w[i-1] through unchanged.
    always_comb begin
        tWord = prevWord;
        if (phase_q == '0) begin
            tWord = subOut ^ {rcon_q, 24'h0};
        end else if (KEY_WORDS == 8 && phase_q == PH_HALF) begin
            tWord = subOut;
        end
    end

    assign newWord = win_q[0] ^ tWord;

    // Sequencing and buffer write selection. In IDLE the key port may write
    // both the window and the buffer, and a simultaneous start sees the
    // updated window on the following cycle. In EXPAND each cycle produces
    // one word, stores it at w[i] and shifts it into the window; the phase
    // counter wraps at Nk so no divider is needed to find i mod Nk.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        rcon_d   = rcon_q;
        win_d    = win_q;
        bufWe    = 1'b0;
        bufWaddr = cnt_q;
        bufWdata = newWord;

        case (state_q)
            ST_IDLE: begin
                if (bus.key_we_i) begin
                    win_d[bus.key_idx_i] = bus.key_data_i;
                    bufWe    = 1'b1;
                    bufWaddr = ADDR_W'(bus.key_idx_i);
                    bufWdata = bus.key_data_i;
                end
                if (bus.start_i) begin
                    state_d = ST_EXPAND;
                    cnt_d   = CNT_INIT;
                    phase_d = '0;
                    rcon_d  = RCON_INIT;
                end
            end
            ST_EXPAND: begin
                bufWe = 1'b1;
                for (int j = 0; j < KEY_WORDS - 1; j++) begin
                    win_d[j] = win_q[j+1];
                end
                win_d[KEY_WORDS-1] = newWord;
                cnt_d   = cnt_q + ADDR_W'(1);
                phase_d = (phase_q == PH_LAST) ? '0 : phase_q + IDX_W'(1);
                if (phase_q == '0) begin
                    rcon_d = aes_xtime(rcon_q);
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered read port. Addresses past the end of the schedule read as
    // zero; in-range reads see the buffer before this cycle's write lands.
    always_comb begin
        rdata_d = 32'h0;
        if (int'(bus.rk_addr_i) < RK_WORDS) begin
            rdata_d = buf_q[bus.rk_addr_i];
        end
    end

    // Control state, window and read register. A reset mid-run returns the
    // engine to a clean idle state with an all-zero window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            rcon_q  <= 8'h00;
            rdata_q <= 32'h0;
            for (int j = 0; j < KEY_WORDS; j++) begin
                win_q[j] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            rcon_q  <= rcon_d;
            rdata_q <= rdata_d;
            win_q   <= win_d;
        end
    end

    // Round-key storage: single write port, no reset, so it can map onto
    // distributed RAM. Its contents are meaningless until rewritten.
    always_ff @(posedge clk_i) begin
        if (bufWe) begin
            buf_q[bufWaddr] <= bufWdata;
        end
    end

    assign bus.busy_o    = (state_q == ST_EXPAND);
    assign bus.done_o    = (state_q == ST_DONE);
    assign bus.rk_data_o = rdata_q;

endmodule

// File: tb/tb_aespim_keyexp_engine.sv
// ---------------------------------------------------------------------------
// tb_aespim_keyexp_engine
// Directed bench for the key-schedule engine with one AES-128 and one
// AES-256 instance sharing clock and reset. Expected words are FIPS-197
// Appendix A values and the all-zero-key schedule.
// ---------------------------------------------------------------------------
module tb_aespim_keyexp_engine;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    logic [31:0] key128 [4];
    logic [31:0] key256 [8];

    aespim_keyexp_engine_if #(.KEY_WORDS(4)) if128 ();
    aespim_keyexp_engine_if #(.KEY_WORDS(8)) if256 ();

    aespim_keyexp_engine #(.KEY_WORDS(4)) dut128 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if128)
    );

    aespim_keyexp_engine #(.KEY_WORDS(8)) dut256 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if256)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge; outputs are then stable to sample
    // and inputs set now are captured at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setStart(input bit sel, input bit v);
        if (sel) if256.start_i = v;
        else     if128.start_i = v;
    endtask

    task automatic setWe(input bit sel, input bit we, input int idx, input logic [31:0] data);
        if (sel) begin
            if256.key_we_i   = we;
            if256.key_idx_i  = idx[2:0];
            if256.key_data_i = data;
        end else begin
            if128.key_we_i   = we;
            if128.key_idx_i  = idx[1:0];
            if128.key_data_i = data;
        end
    endtask

    task automatic setAddr(input bit sel, input int a);
        if (sel) if256.rk_addr_i = a[5:0];
        else     if128.rk_addr_i = a[5:0];
    endtask

    function automatic logic getBusy(input bit sel);
        return sel ? if256.busy_o : if128.busy_o;
    endfunction

    function automatic logic getDone(input bit sel);
        return sel ? if256.done_o : if128.done_o;
    endfunction

    function automatic logic [31:0] getData(input bit sel);
        return sel ? if256.rk_data_o : if128.rk_data_o;
    endfunction

    task automatic readWord(input bit sel, input int a, output logic [31:0] d);
        setAddr(sel, a);
        tick();
        d = getData(sel);
    endtask

    task automatic loadKey(input bit sel);
        for (int i = 0; i < (sel ? 8 : 4); i++) begin
            setWe(sel, 1'b1, i, sel ? key256[i] : key128[i]);
            tick();
        end
        setWe(sel, 1'b0, 0, 32'h0);
    endtask

    task automatic startNow(input bit sel);
        setStart(sel, 1'b1);
        tick();
        setStart(sel, 1'b0);
    endtask

    // Follow an expansion from cycle cyc0 (cycle 1 is the first after the
    // start edge) until done_o, optionally hammering start/key_we meanwhile.
    task automatic runExpand(input bit sel, input bit pulse, input int cyc0,
                             output int busyCnt, output int doneAt,
                             output bit gap, output bit busyAtDone);
        int cyc;
        bit busyEnded;
        cyc        = cyc0;
        busyCnt    = 0;
        doneAt     = -1;
        gap        = 1'b0;
        busyEnded  = 1'b0;
        busyAtDone = 1'b0;
        while (cyc < 200) begin
            if (getDone(sel)) begin
                doneAt     = cyc;
                busyAtDone = getBusy(sel);
                break;
            end
            if (getBusy(sel)) begin
                busyCnt++;
                if (busyEnded) gap = 1'b1;
            end else if (busyCnt > 0) begin
                busyEnded = 1'b1;
            end
            if (pulse) begin
                setStart(sel, cyc[0]);
                setWe(sel, cyc[0], cyc % (sel ? 8 : 4), 32'hdeadbeef ^ cyc);
            end
            tick();
            cyc++;
        end
        setStart(sel, 1'b0);
        setWe(sel, 1'b0, 0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (if128.busy_o !== 1'b0 || if128.done_o !== 1'b0 || if128.rk_data_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset128: got busy=%b done=%b data=%h, expected 0 0 00000000",
                     if128.busy_o, if128.done_o, if128.rk_data_o);
        end
        vectors++;
        if (if256.busy_o !== 1'b0 || if256.done_o !== 1'b0 || if256.rk_data_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset256: got busy=%b done=%b data=%h, expected 0 0 00000000",
                     if256.busy_o, if256.done_o, if256.rk_data_o);
        end
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_key();
        int bc, da;
        bit gap, bad;
        logic [31:0] d;
        startNow(0);
        runExpand(0, 0, 1, bc, da, gap, bad);
        vectors++;
        if (bc !== 40 || gap || da !== 41 || bad) begin
            miscompares++;
            $display("[TB] FAIL zero_timing: got busy=%0d gap=%0d done_at=%0d busy_at_done=%0d, expected 40 0 41 0",
                     bc, gap, da, bad);
        end
        tick();
        readWord(0, 4, d);
        vectors++;
        if (d !== 32'h62636363) begin
            miscompares++;
            $display("[TB] FAIL zero_w4: got %h, expected 62636363", d);
        end
        readWord(0, 7, d);
        vectors++;
        if (d !== 32'h62636363) begin
            miscompares++;
            $display("[TB] FAIL zero_w7: got %h, expected 62636363", d);
        end
    endtask

    task automatic test_aes128();
        int addrs [8] = '{0, 5, 6, 7, 40, 41, 42, 43};
        logic [31:0] exps [8] = '{32'h2b7e1516, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605,
                                  32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6};
        int bc, da;
        bit gap, bad;
        logic [31:0] d;
        loadKey(0);
        setAddr(0, 4);
        startNow(0);
        tick();
        vectors++;
        if (if128.rk_data_o !== 32'h62636363) begin
            miscompares++;
            $display("[TB] FAIL rbw_old: got %h, expected 62636363", if128.rk_data_o);
        end
        tick();
        vectors++;
        if (if128.rk_data_o !== 32'ha0fafe17) begin
            miscompares++;
            $display("[TB] FAIL rbw_new: got %h, expected a0fafe17", if128.rk_data_o);
        end
        runExpand(0, 0, 3, bc, da, gap, bad);
        vectors++;
        if (da !== 41 || bad) begin
            miscompares++;
            $display("[TB] FAIL a128_done: got done_at=%0d busy_at_done=%0d, expected 41 0", da, bad);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            readWord(0, addrs[k], d);
            vectors++;
            if (d !== exps[k]) begin
                miscompares++;
                $display("[TB] FAIL a128_w%0d: got %h, expected %h", addrs[k], d, exps[k]);
            end
        end
    endtask

    task automatic test_aes256();
        int addrs [10] = '{0, 7, 8, 9, 10, 11, 12, 56, 57, 58};
        logic [31:0] exps [10] = '{32'h603deb10, 32'h0914dff4, 32'h9ba35411, 32'h8e6925af,
                                   32'ha51a8b5f, 32'h2067fcde, 32'ha8b09c1a, 32'hfe4890d1,
                                   32'he6188d0b, 32'h046df344};
        int bc, da;
        bit gap, bad;
        logic [31:0] d;
        loadKey(1);
        startNow(1);
        runExpand(1, 0, 1, bc, da, gap, bad);
        vectors++;
        if (bc !== 52 || gap || da !== 53 || bad) begin
            miscompares++;
            $display("[TB] FAIL a256_timing: got busy=%0d gap=%0d done_at=%0d busy_at_done=%0d, expected 52 0 53 0",
                     bc, gap, da, bad);
        end
        tick();
        for (int k = 0; k < 10; k++) begin
            readWord(1, addrs[k], d);
            vectors++;
            if (d !== exps[k]) begin
                miscompares++;
                $display("[TB] FAIL a256_w%0d: got %h, expected %h", addrs[k], d, exps[k]);
            end
        end
        readWord(1, 59, d);
        vectors++;
        if (d !== 32'h706c631e) begin
            miscompares++;
            $display("[TB] FAIL a256_w59: got %h, expected 706c631e", d);
        end
    endtask

    task automatic test_ignore_while_busy();
        int bc, da;
        bit gap, bad;
        logic [31:0] d;
        loadKey(0);
        startNow(0);
        runExpand(0, 1, 1, bc, da, gap, bad);
        vectors++;
        if (bc !== 40 || gap || da !== 41 || bad) begin
            miscompares++;
            $display("[TB] FAIL busy_ignore_timing: got busy=%0d gap=%0d done_at=%0d busy_at_done=%0d, expected 40 0 41 0",
                     bc, gap, da, bad);
        end
        tick();
        readWord(0, 4, d);
        vectors++;
        if (d !== 32'ha0fafe17) begin
            miscompares++;
            $display("[TB] FAIL busy_ignore_w4: got %h, expected a0fafe17", d);
        end
        readWord(0, 43, d);
        vectors++;
        if (d !== 32'hb6630ca6) begin
            miscompares++;
            $display("[TB] FAIL busy_ignore_w43: got %h, expected b6630ca6", d);
        end
    endtask

    task automatic test_same_cycle_start();
        int bc, da;
        bit gap, bad;
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            setWe(0, 1'b1, i, key128[i]);
            tick();
        end
        setWe(0, 1'b1, 3, key128[3]);
        setStart(0, 1'b1);
        tick();
        setWe(0, 1'b0, 0, 32'h0);
        setStart(0, 1'b0);
        runExpand(0, 0, 1, bc, da, gap, bad);
        vectors++;
        if (da !== 41) begin
            miscompares++;
            $display("[TB] FAIL same_cycle_done: got done_at=%0d, expected 41", da);
        end
        tick();
        readWord(0, 4, d);
        vectors++;
        if (d !== 32'ha0fafe17) begin
            miscompares++;
            $display("[TB] FAIL same_cycle_w4: got %h, expected a0fafe17", d);
        end
        readWord(0, 43, d);
        vectors++;
        if (d !== 32'hb6630ca6) begin
            miscompares++;
            $display("[TB] FAIL same_cycle_w43: got %h, expected b6630ca6", d);
        end
    endtask

    task automatic test_reset_mid();
        int bc, da;
        bit gap, bad;
        logic [31:0] d;
        loadKey(0);
        setAddr(0, 0);
        startNow(0);
        repeat (19) tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (if128.busy_o !== 1'b0 || if128.done_o !== 1'b0 || if128.rk_data_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got busy=%b done=%b data=%h, expected 0 0 00000000",
                     if128.busy_o, if128.done_o, if128.rk_data_o);
        end
        #1;
        rst_n = 1'b1;
        tick();
        loadKey(0);
        startNow(0);
        runExpand(0, 0, 1, bc, da, gap, bad);
        vectors++;
        if (bc !== 40 || da !== 41) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_timing: got busy=%0d done_at=%0d, expected 40 41", bc, da);
        end
        tick();
        readWord(0, 4, d);
        vectors++;
        if (d !== 32'ha0fafe17) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_w4: got %h, expected a0fafe17", d);
        end
        readWord(0, 43, d);
        vectors++;
        if (d !== 32'hb6630ca6) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_w43: got %h, expected b6630ca6", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        readWord(0, 63, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL oor128_63: got %h, expected 00000000", d);
        end
        readWord(0, 44, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL oor128_44: got %h, expected 00000000", d);
        end
        readWord(0, 43, d);
        vectors++;
        if (d !== 32'hb6630ca6) begin
            miscompares++;
            $display("[TB] FAIL inrange128_43: got %h, expected b6630ca6", d);
        end
        readWord(1, 60, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL oor256_60: got %h, expected 00000000", d);
        end
    endtask

    task automatic test_back_to_back();
        int bc, da;
        bit gap, bad;
        startNow(0);
        runExpand(0, 0, 1, bc, da, gap, bad);
        setStart(0, 1'b1);
        tick();
        vectors++;
        if (if128.busy_o !== 1'b0 || if128.done_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL start_in_done: got busy=%b done=%b, expected 0 0",
                     if128.busy_o, if128.done_o);
        end
        tick();
        setStart(0, 1'b0);
        vectors++;
        if (if128.busy_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_accept: got busy=%b, expected 1", if128.busy_o);
        end
        runExpand(0, 0, 1, bc, da, gap, bad);
        vectors++;
        if (bc !== 40 || gap || da !== 41 || bad) begin
            miscompares++;
            $display("[TB] FAIL b2b_timing: got busy=%0d gap=%0d done_at=%0d busy_at_done=%0d, expected 40 0 41 0",
                     bc, gap, da, bad);
        end
        tick();
        vectors++;
        if (if128.done_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_done_pulse: got done=%b, expected 0", if128.done_o);
        end
    endtask

    // Single sequencer: initialise, run each scenario, report.
    initial begin
        vectors     = 0;
        miscompares = 0;
        key128 = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
        key256 = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                   32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
        rst_n = 1'b0;
        setStart(0, 1'b0);
        setStart(1, 1'b0);
        setWe(0, 1'b0, 0, 32'h0);
        setWe(1, 1'b0, 0, 32'h0);
        setAddr(0, 0);
        setAddr(1, 0);

        $display("[TB] starting aespim_keyexp_engine bench");
        test_reset();
        test_zero_key();
        test_aes128();
        test_aes256();
        test_ignore_while_busy();
        test_same_cycle_start();
        test_reset_mid();
        test_out_of_range();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aespim_keyexp_engine.md
# aespim_keyexp_engine

Parametrised AES key-schedule engine for the aespim accelerator. It generates the full AES-128 or AES-256 round-key schedule autonomously, one 32-bit word per cycle, after a single start command. The initial key is loaded word-serially. Finished round keys are stored in an internal buffer that the datapath reads by word address. It replaces per-instruction software-driven key-expansion steps with a self-sequenced block that has a start/busy/done handshake.

## Interface
- `KEY_WORDS`, default 4: Nk; legal values 4 (AES-128) and 8 (AES-256). Any other value is an elaboration error.
- `RK_WORDS`, derived: 4·(Nr+1), where Nr = Nk+6. Gives 44 for Nk=4 and 60 for Nk=8.
- `ADDR_W`, derived: $clog2(RK_WORDS), which is 6 for both legal Nk.
- `clk_i`, in, 1: single clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `key_we_i`, in, 1: write one initial key word.
- `key_idx_i`, in, $clog2(KEY_WORDS): index of that key word; index 0 is w[0].
- `key_data_i`, in, 32: key word, with byte 0 in bits [31:24].
- `start_i`, in, 1: begin expansion; sampled in IDLE only.
- `busy_o`, out, 1: expansion in progress.
- `done_o`, out, 1: one-cycle completion pulse.
- `rk_addr_i`, in, ADDR_W: round-key word read address.
- `rk_data_o`, out, 32: registered read data.

## Operation
- FSM states are IDLE, EXPAND and DONE. Reset state is IDLE.
- IDLE → EXPAND on `start_i`. EXPAND → DONE after the last word is written. DONE → IDLE unconditionally after one cycle.
- Key load is accepted only in IDLE.
  - `key_we_i` writes `key_data_i` to buffer[key_idx_i] and to window slot key_idx_i.
  - In EXPAND or DONE, `key_we_i` is ignored.
- Window: a shift register of KEY_WORDS words holding w[i-Nk]..w[i-1].
- On the start edge:
  - word counter i ← Nk;
  - phase counter i mod Nk ← 0;
  - rcon ← 0x01.
- Each EXPAND cycle computes w[i] from t = w[i-1]:
  - If i mod Nk == 0: t = SubWord(RotWord(t)) ^ {rcon, 24'h0}. RotWord(x) = {x[23:0], x[31:24]}. After use, rcon ← xtime(rcon), where xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - Else if Nk == 8 and i mod Nk == 4: t = SubWord(t).
  - w[i] = w[i-Nk] ^ t.
  - w[i] is written to buffer[i] and shifted into the window.
  - i increments. The phase counter wraps at Nk; no modulo divider is used.
- SubWord uses four byte S-boxes in forward (encrypt) mode and is shared by both substitution cases.
- Reads:
  - rk_data_o ← buffer[rk_addr_i] each cycle, read-before-write.
  - An address ≥ RK_WORDS returns 32'h0.
  - Reads during EXPAND are legal and return the current contents, which may be stale.
- Boundaries:
  - `start_i` while busy is ignored.
  - `start_i` and `key_we_i` in the same IDLE cycle: the key write takes effect and expansion starts from the updated window.
  - `start_i` with no key loaded expands whatever the window holds; zeros after reset.
  - A second start after DONE re-expands from the current window. The window now holds the last Nk generated words, so software must reload the key first.
- Reset mid-expansion:
  - FSM → IDLE; counters, rcon and window cleared; outputs take their reset values.
  - Buffer contents are undefined after reset. The buffer is not reset.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `rk_data_o`=32'h0.
- With `start_i` sampled at edge T:
  - `busy_o`=1 during cycles T+1 … T+G, where G = RK_WORDS−Nk (40 or 52);
  - word w[Nk+k] is written at edge T+1+k;
  - `done_o`=1 only in cycle T+G+1, with `busy_o`=0 in that cycle.
- A new start is accepted from cycle T+G+2 (IDLE).
- Read latency is 1 cycle: the address presented at edge E gives data valid after E.
- Worst-case combinational path: window → RotWord → S-box → XOR → buffer.

## Structure
- `aespim_pkg` holds:
  - the `keyexp_state_e` enum (IDLE/EXPAND/DONE);
  - the `AES_RK_WORDS(nk)` function;
  - the `aes_xtime` function;
  - the localparam `RCON_INIT` = 8'h01.
- Sub-module: `aespim_subword`, which wraps four `bSbox` instances with `encrypt` tied to 1 and maps a 32→32 word.
- The buffer is an unreset flop array of RK_WORDS × 32 and must be inferable as distributed RAM.

## Test plan
- AES-128: load FIPS-197 A.1 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, start → w[4]=a0fafe17, w[43]=b6630ca6; done_o exactly 41 cycles after start.
- AES-256 (KEY_WORDS=8): load 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, start → w[8]=9ba35411, w[59]=706c631e; done_o after 53 cycles.
- Pulse `start_i` and `key_we_i` repeatedly mid-EXPAND → result identical to the clean run; busy_o stays high continuously for exactly G cycles.
- Assert rst_ni low at cycle 20 of EXPAND → busy_o, done_o and rk_data_o are 0 immediately; after reset, reload the key and start → correct A.1 vector.
- Read rk_addr_i=63 with KEY_WORDS=4 → 32'h0. Read address 4 at the cycle it is written → old value, then a0fafe17 on the next read.
- Start immediately after DONE without reloading → busy/done timing is unchanged; no check on the data.
